// File: rtl/vga_axil_slave_ctrl.sv
// vga_axil_slave_ctrl
// AXI-Lite slave that turns each AXI-Lite write/read into a single-cycle
// native strobe towards a word-addressed register file or memory.
// Write and read channels run as two independent FSMs. A read that would be
// issued in the same cycle as a native write waits one cycle, so it always
// observes that write.
// Optional build macro: VGA_AXIL_WSTRB_EN. When defined, AXI byte strobes are
// forwarded on strb_o and an all-zero strobe is a no-op write. When undefined,
// strb_o is all ones and wstrb_i is ignored.
module vga_axil_slave_ctrl #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int NUM_WORDS       = 64,
    parameter int READ_LATENCY    = 1,
    localparam int STRB_W         = AXIL_DATA_WIDTH / 8,
    localparam int OFF_W          = $clog2(STRB_W),
    localparam int NATIVE_AW      = AXIL_ADDR_WIDTH - OFF_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // write address channel
    input  logic [AXIL_ADDR_WIDTH-1:0] awaddr_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    // write data channel
    input  logic [AXIL_DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]          wstrb_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    // write response channel
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    // read address channel
    input  logic [AXIL_ADDR_WIDTH-1:0] araddr_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    // read data channel
    output logic [AXIL_DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    // native write port
    output logic [NATIVE_AW-1:0]       addr_write_o,
    output logic [AXIL_DATA_WIDTH-1:0] data_o,
    output logic [STRB_W-1:0]          strb_o,
    output logic                       write_en_o,
    // native read port
    output logic [NATIVE_AW-1:0]       addr_read_o,
    output logic                       read_en_o,
    input  logic [AXIL_DATA_WIDTH-1:0] data_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Latency counter only needs to reach READ_LATENCY-1 (max 3).
    localparam int              CNT_W     = 2;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);

    // One extra bit so NUM_WORDS == 2**NATIVE_AW is representable.
    localparam logic [NATIVE_AW:0] WORDS_LIMIT = (NATIVE_AW + 1)'(NUM_WORDS);

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_EXEC,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    wr_state_t wr_state;
    wr_state_t wr_next;
    rd_state_t rd_state;
    rd_state_t rd_next;

    logic [CNT_W-1:0]           lat_cnt;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q;
    logic                       wr_in_range;
    logic                       rd_in_range;
    logic                       wr_strb_any;

    function automatic logic word_in_range(input logic [NATIVE_AW-1:0] idx);
        return {1'b0, idx} < WORDS_LIMIT;
    endfunction

    assign wr_in_range = word_in_range(addr_write_o);
    assign rd_in_range = word_in_range(addr_read_o);

    // Byte-offset bits of the AXI addresses carry no meaning for word access.
    logic unused_addr_offset;
    assign unused_addr_offset = ^{awaddr_i[OFF_W-1:0], araddr_i[OFF_W-1:0]};

`ifdef VGA_AXIL_WSTRB_EN
    logic [STRB_W-1:0] strb_q;
    assign strb_o      = strb_q;
    assign wr_strb_any = |strb_q;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb_i;
    assign strb_o       = '1;
    assign wr_strb_any  = 1'b1;
`endif

    assign rdata_o = rdata_q;

    // State registers for the write and read channel FSMs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Write FSM: next state, channel handshakes and the native write strobe
    always_comb begin
        wr_next    = wr_state;
        awready_o  = 1'b0;
        wready_o   = 1'b0;
        bvalid_o   = 1'b0;
        bresp_o    = RESP_OKAY;
        write_en_o = 1'b0;
        if (!rst_i) begin
            case (wr_state)
                WR_IDLE: begin
                    awready_o = 1'b1;
                    wready_o  = 1'b1;
                    if (awvalid_i && wvalid_i) begin
                        wr_next = WR_EXEC;
                    end else if (awvalid_i) begin
                        wr_next = WR_WAIT_W;
                    end else if (wvalid_i) begin
                        wr_next = WR_WAIT_AW;
                    end
                end
                WR_WAIT_W: begin
                    wready_o = 1'b1;
                    if (wvalid_i) begin
                        wr_next = WR_EXEC;
                    end
                end
                WR_WAIT_AW: begin
                    awready_o = 1'b1;
                    if (awvalid_i) begin
                        wr_next = WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    write_en_o = wr_in_range && wr_strb_any;
                    wr_next    = WR_RESP;
                end
                WR_RESP: begin
                    bvalid_o = 1'b1;
                    bresp_o  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    if (bready_i) begin
                        wr_next = WR_IDLE;
                    end
                end
                default: wr_next = WR_IDLE;
            endcase
        end
    end

    // Write capture: address and data are latched on their own handshakes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_write_o <= '0;
            data_o       <= '0;
`ifdef VGA_AXIL_WSTRB_EN
            strb_q       <= '0;
`endif
        end else begin
            if (awvalid_i && awready_o) begin
                addr_write_o <= awaddr_i[AXIL_ADDR_WIDTH-1:OFF_W];
            end
            if (wvalid_i && wready_o) begin
                data_o <= wdata_i;
`ifdef VGA_AXIL_WSTRB_EN
                strb_q <= wstrb_i;
`endif
            end
        end
    end

    // Read FSM: next state, AR/R handshakes and the native read strobe.
    // A read in RD_EXEC yields to a native write in the same cycle.
    always_comb begin
        rd_next   = rd_state;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        rresp_o   = RESP_OKAY;
        read_en_o = 1'b0;
        if (!rst_i) begin
            case (rd_state)
                RD_IDLE: begin
                    arready_o = 1'b1;
                    if (arvalid_i) begin
                        rd_next = RD_EXEC;
                    end
                end
                RD_EXEC: begin
                    if (!write_en_o) begin
                        read_en_o = rd_in_range;
                        rd_next   = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        rd_next = RD_RESP;
                    end
                end
                RD_RESP: begin
                    rvalid_o = 1'b1;
                    rresp_o  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    if (rready_i) begin
                        rd_next = RD_IDLE;
                    end
                end
                default: rd_next = RD_IDLE;
            endcase
        end
    end

    // Read address capture, latency count and sampling of native read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_read_o <= '0;
            lat_cnt     <= '0;
            rdata_q     <= '0;
        end else begin
            if (arvalid_i && arready_o) begin
                addr_read_o <= araddr_i[AXIL_ADDR_WIDTH-1:OFF_W];
            end
            if (rd_state == RD_EXEC) begin
                lat_cnt <= '0;
            end else if (rd_state == RD_WAIT) begin
                lat_cnt <= lat_cnt + CNT_W'(1);
            end
            if (rd_state == RD_WAIT && lat_cnt == LAT_LAST) begin
                rdata_q <= rd_in_range ? data_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_axil_slave_ctrl.sv
// tb_vga_axil_slave_ctrl
// Bench for vga_axil_slave_ctrl (32-bit data, 16-bit address, 64 words,
// read latency 2). A behavioural memory drives data_i; expected results come
// from a word-array model updated only with the bench's own writes.
module tb_vga_axil_slave_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int NW  = 64;
    localparam int RL  = 2;
    localparam int NAW = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [NAW-1:0]  addr_write;
    logic [DW-1:0]   data_w;
    logic [3:0]      strb;
    logic            write_en;
    logic [NAW-1:0]  addr_read;
    logic            read_en;
    logic [DW-1:0]   data_r;

    always #5 clk = ~clk;

    vga_axil_slave_ctrl #(
        .AXIL_DATA_WIDTH(DW),
        .AXIL_ADDR_WIDTH(AW),
        .NUM_WORDS(NW),
        .READ_LATENCY(RL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .awaddr_i(awaddr),
        .awvalid_i(awvalid),
        .awready_o(awready),
        .wdata_i(wdata),
        .wstrb_i(wstrb),
        .wvalid_i(wvalid),
        .wready_o(wready),
        .bresp_o(bresp),
        .bvalid_o(bvalid),
        .bready_i(bready),
        .araddr_i(araddr),
        .arvalid_i(arvalid),
        .arready_o(arready),
        .rdata_o(rdata),
        .rresp_o(rresp),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .addr_write_o(addr_write),
        .data_o(data_w),
        .strb_o(strb),
        .write_en_o(write_en),
        .addr_read_o(addr_read),
        .read_en_o(read_en),
        .data_i(data_r)
    );

    // ---------------- native memory environment ----------------
    logic [DW-1:0]  mem [NW];
    logic [DW-1:0]  pipe_d [RL+1];
    logic           pipe_v [RL+1];
    bit             env_init = 1'b0;
    int             we_cnt = 0;
    int             re_cnt = 0;
    logic [NAW-1:0] we_addr = '0;
    logic [DW-1:0]  we_data = '0;
    logic [NAW-1:0] re_addr = '0;

    always @(negedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
            for (int i = 0; i <= RL; i++) begin
                pipe_d[i] <= '0;
                pipe_v[i] <= 1'b0;
            end
            env_init <= 1'b1;
        end else begin
            if (write_en) begin
                we_cnt  <= we_cnt + 1;
                we_addr <= addr_write;
                we_data <= data_w;
                if (int'(addr_write) < NW)
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) mem[addr_write][8*b +: 8] <= data_w[8*b +: 8];
            end
            if (read_en) begin
                re_cnt  <= re_cnt + 1;
                re_addr <= addr_read;
            end
            for (int i = RL; i > 0; i--) begin
                pipe_d[i] <= pipe_d[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
            pipe_v[0] <= read_en;
            pipe_d[0] <= (read_en && int'(addr_read) < NW) ? mem[addr_read] : 32'h0;
        end
    end

    assign data_r = pipe_v[RL] ? pipe_d[RL] : 32'hBAD0_BAD0;

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [NW];

    function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef VGA_AXIL_WSTRB_EN
        return s;
`else
        return 4'hF;
`endif
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [3:0] s);
        int idx;
        logic [3:0] e;
        idx = int'(a) / 4;
        e = eff_strb(s);
        if (idx < NW)
            for (int b = 0; b < 4; b++)
                if (e[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_b(input int b_dly, output logic [1:0] resp);
        bit got;
        got  = 1'b0;
        resp = 2'b11;
        for (int c = 0; c < 40 && !got; c++) begin
            bready = (c >= b_dly);
            @(negedge clk);
            if (bvalid && bready) begin
                resp = bresp;
                got  = 1'b1;
            end
            @(posedge clk); #1;
        end
        bready = 1'b0;
        chk("b_handshake_timeout", 64'(got), 64'(1));
    endtask

    task automatic wait_r(input int r_dly, output logic [DW-1:0] d, output logic [1:0] resp);
        bit got;
        got  = 1'b0;
        resp = 2'b11;
        d    = '1;
        for (int c = 0; c < 40 && !got; c++) begin
            rready = (c >= r_dly);
            @(negedge clk);
            if (rvalid && rready) begin
                resp = rresp;
                d    = rdata;
                got  = 1'b1;
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        chk("r_handshake_timeout", 64'(got), 64'(1));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int nstrobe);
        int we0;
        bit aw_done, w_done;
        we0 = we_cnt;
        aw_done = 1'b0;
        w_done  = 1'b0;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            @(negedge clk);
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("aw_w_accept_timeout", 64'(aw_done && w_done), 64'(1));
        wait_b(b_dly, resp);
        nstrobe = we_cnt - we0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                           output logic [DW-1:0] d, output logic [1:0] resp, output int nstrobe);
        int re0;
        bit done;
        re0  = re_cnt;
        done = 1'b0;
        araddr = a;
        for (int c = 0; c < 40 && !done; c++) begin
            arvalid = (c >= ar_dly);
            @(negedge clk);
            if (arvalid && arready) done = 1'b1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        chk("ar_accept_timeout", 64'(done), 64'(1));
        wait_r(r_dly, d, resp);
        nstrobe = re_cnt - re0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            dly_a;
        int            dly_w;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_rdata;
        int            exp_strobes;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1:0]    resp;
        logic [DW-1:0] d;
        logic [DW-1:0] held;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_exp;
        logic [3:0]    rs;
        int            ns;
        int            we0;
        int            re0;
        int            idx;
        bit            inr;

        // in-range edges, offset-ignoring, out-of-range, untouched words
        vecs[0]  = '{1'b0, 16'h0100, 32'h0,          0, 0, 2'b10, 32'h0,          0};
        vecs[1]  = '{1'b1, 16'h0104, 32'hFFFF_FFFF,  0, 0, 2'b10, 32'h0,          0};
        vecs[2]  = '{1'b1, 16'h00FE, 32'hCAFE_F00D,  0, 2, 2'b00, 32'h0,          1};
        vecs[3]  = '{1'b0, 16'h00FC, 32'h0,          0, 0, 2'b00, 32'hCAFE_F00D,  1};
        vecs[4]  = '{1'b0, 16'h00FF, 32'h0,          1, 0, 2'b00, 32'hCAFE_F00D,  1};
        vecs[5]  = '{1'b0, 16'h0014, 32'h0,          0, 0, 2'b00, 32'h5A00_0005,  1};
        vecs[6]  = '{1'b1, 16'hFFFC, 32'h0000_0001,  2, 0, 2'b10, 32'h0,          0};
        vecs[7]  = '{1'b0, 16'hFFFF, 32'h0,          0, 0, 2'b10, 32'h0,          0};
        vecs[8]  = '{1'b0, 16'h0010, 32'h0,          0, 0, 2'b00, 32'h0000_00A5,  1};
        vecs[9]  = '{1'b1, 16'h0000, 32'h0BAD_F00D,  1, 1, 2'b00, 32'h0,          1};
        vecs[10] = '{1'b0, 16'h0003, 32'h0,          0, 0, 2'b00, 32'h0BAD_F00D,  1};

        for (int i = 0; i < NW; i++) model_mem[i] = 32'h5A00_0000 | 32'(i);

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_strobes", 64'({write_en, read_en}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_readies", 64'({awready, wready, arready}), 64'(3'b111));
        chk("idle_valids", 64'({bvalid, rvalid}), 64'(0));
        @(posedge clk); #1;

        // ---- AW and W in the same cycle: exact write timing ----
        awaddr = 16'h0010; wdata = 32'h0000_00A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        chk("t1_c0_ready", 64'({awready, wready}), 64'(2'b11));
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("t1_c1_write_en", 64'(write_en), 64'(1));
        chk("t1_c1_addr", 64'(addr_write), 64'(4));
        chk("t1_c1_data", 64'(data_w), 64'(32'hA5));
        chk("t1_c1_bvalid", 64'(bvalid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_c2_bvalid", 64'(bvalid), 64'(1));
        chk("t1_c2_bresp", 64'(bresp), 64'(2'b00));
        chk("t1_c2_write_en", 64'(write_en), 64'(0));
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("t1_c3_back_idle", 64'({bvalid, awready, wready}), 64'(3'b011));
        model_write(16'h0010, 32'h0000_00A5, 4'hF);
        @(posedge clk); #1;

        // ---- W three cycles ahead of AW ----
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; awaddr = 16'h0020;
        we0 = we_cnt;
        @(negedge clk);
        chk("t2_w_ready", 64'(wready), 64'(1));
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t2_wait%0d_awready", c), 64'(awready), 64'(1));
            chk($sformatf("t2_wait%0d_wready", c), 64'(wready), 64'(0));
            chk($sformatf("t2_wait%0d_write_en", c), 64'(write_en), 64'(0));
            @(posedge clk); #1;
        end
        awvalid = 1'b1;
        @(negedge clk);
        chk("t2_aw_ready", 64'(awready), 64'(1));
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("t2_write_en", 64'(write_en), 64'(1));
        chk("t2_addr", 64'(addr_write), 64'(8));
        chk("t2_data", 64'(data_w), 64'(32'h1234_5678));
        @(posedge clk); #1;
        wait_b(0, resp);
        chk("t2_bresp", 64'(resp), 64'(2'b00));
        chk("t2_single_strobe", 64'(we_cnt - we0), 64'(1));
        model_write(16'h0020, 32'h1234_5678, 4'hF);
        do_read(16'h0020, 0, 0, d, resp, ns);
        chk("t2_readback", 64'(d), 64'(32'h1234_5678));
        chk("t2_rresp", 64'(resp), 64'(2'b00));

        // ---- vector table ----
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, 4'hF, vecs[i].dly_a, vecs[i].dly_w, 0, resp, ns);
                model_write(vecs[i].addr, vecs[i].data, 4'hF);
                chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_wstrobes", i), 64'(ns), 64'(vecs[i].exp_strobes));
                if (vecs[i].exp_strobes != 0)
                    chk($sformatf("vec%0d_waddr", i), 64'(we_addr), 64'(vecs[i].addr >> 2));
            end else begin
                do_read(vecs[i].addr, vecs[i].dly_a, 0, d, resp, ns);
                chk($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].exp_rdata));
                chk($sformatf("vec%0d_rstrobes", i), 64'(ns), 64'(vecs[i].exp_strobes));
            end
        end

        // ---- simultaneous AR/AW/W to the same word: read sees new value ----
        do_write(16'h0008, 32'h0000_0011, 4'hF, 0, 0, 0, resp, ns);
        model_write(16'h0008, 32'h0000_0011, 4'hF);
        awaddr = 16'h0008; araddr = 16'h0008; wdata = 32'h0000_0022; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        chk("t4_c0_readies", 64'({awready, wready, arready}), 64'(3'b111));
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("t4_c1_write_en", 64'(write_en), 64'(1));
        chk("t4_c1_read_en", 64'(read_en), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_c2_read_en", 64'(read_en), 64'(1));
        chk("t4_c2_addr_read", 64'(addr_read), 64'(2));
        chk("t4_c2_write_en", 64'(write_en), 64'(0));
        @(posedge clk); #1;
        bready = 1'b0;
        model_write(16'h0008, 32'h0000_0022, 4'hF);
        wait_r(0, d, resp);
        chk("t4_rdata", 64'(d), 64'(32'h22));
        chk("t4_rresp", 64'(resp), 64'(2'b00));

        // ---- rready held low: response must stay stable ----
        araddr = 16'h0008; arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        arvalid = 1'b0;
        begin : wait_rvalid
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (rvalid) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("t5_rvalid_timeout", 64'(seen), 64'(1));
        end
        held = rdata;
        chk("t5_held_value", 64'(held), 64'(32'h22));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t5_stall%0d_rvalid", c), 64'(rvalid), 64'(1));
            chk($sformatf("t5_stall%0d_rdata", c), 64'(rdata), 64'(held));
            chk($sformatf("t5_stall%0d_arready", c), 64'(arready), 64'(0));
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        chk("t5_release_rvalid", 64'(rvalid), 64'(1));
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("t5_after_idle", 64'({rvalid, arready}), 64'(2'b01));
        @(posedge clk); #1;

        // ---- reset while the write response is pending ----
        awaddr = 16'h0030; wdata = 32'h0000_0077; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(16'h0030, 32'h0000_0077, 4'hF);
        begin : wait_bvalid
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (bvalid) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("t6_bvalid_timeout", 64'(seen), 64'(1));
        end
        we0 = we_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_write_en", 64'(write_en), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_bvalid_dropped", 64'(bvalid), 64'(0));
        chk("t6_readies", 64'({awready, wready}), 64'(2'b11));
        @(posedge clk); #1;
        chk("t6_no_extra_strobe", 64'(we_cnt - we0), 64'(0));
        do_read(16'h0030, 0, 0, d, resp, ns);
        chk("t6_readback", 64'(d), 64'(32'h77));

        // ---- randomized transactions against the model ----
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) != 0) idx = $urandom_range(0, NW - 1);
            else                           idx = $urandom_range(NW, 16383);
            inr = (idx < NW);
            ra  = 16'(idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d  = $urandom;
                rs = 4'($urandom_range(0, 15));
                do_write(ra, d, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), resp, ns);
                model_write(ra, d, rs);
                chk($sformatf("rnd%0d_bresp", t), 64'(resp), inr ? 64'(0) : 64'(2));
                chk($sformatf("rnd%0d_wstrobes", t), 64'(ns),
                    64'(inr && eff_strb(rs) != 4'h0));
                if (inr && eff_strb(rs) != 4'h0)
                    chk($sformatf("rnd%0d_waddr", t), 64'(we_addr), 64'(idx));
            end else begin
                rd_exp = inr ? model_mem[idx] : 32'h0;
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), d, resp, ns);
                chk($sformatf("rnd%0d_rresp", t), 64'(resp), inr ? 64'(0) : 64'(2));
                chk($sformatf("rnd%0d_rdata", t), 64'(d), 64'(rd_exp));
                chk($sformatf("rnd%0d_rstrobes", t), 64'(ns), 64'(inr));
                if (inr)
                    chk($sformatf("rnd%0d_raddr", t), 64'(re_addr), 64'(idx));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_axil_slave_ctrl.md
Name: vga_axil_slave_ctrl

Overview:
Parametrised successor of the AXI-Lite slave FSM. Converts AXI-Lite slave transactions into single-cycle native write/read strobes towards a register file or memory inside the VGA core. Adds generic data/address widths, address-range decode with SLVERR, and a configurable native read latency. Write and read channels run concurrently, with a defined collision rule.

Parameters:
AXIL_DATA_WIDTH, 32, AXI-Lite data width; 32 or 64.
AXIL_ADDR_WIDTH, 16, AXI-Lite byte address width.
NUM_WORDS, 64, number of native words. Word index >= NUM_WORDS is out of range.
READ_LATENCY, 1, cycles from read_en_o to data_i valid; range 1..4.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
awaddr_i / awvalid_i / awready_o  in/in/out  AXIL_ADDR_WIDTH/1/1  write address channel
wdata_i / wstrb_i / wvalid_i / wready_o  in/in/in/out  AXIL_DATA_WIDTH/AXIL_DATA_WIDTH/8/1/1  write data channel
bresp_o / bvalid_o / bready_i  out/out/in  2/1/1  write response channel
araddr_i / arvalid_i / arready_o  in/in/out  AXIL_ADDR_WIDTH/1/1  read address channel
rdata_o / rresp_o / rvalid_o / rready_i  out/out/out/in  AXIL_DATA_WIDTH/2/1/1  read data channel
addr_write_o  out  NATIVE_AW  native write word index; NATIVE_AW = AXIL_ADDR_WIDTH - log2(AXIL_DATA_WIDTH/8)
data_o / strb_o  out  AXIL_DATA_WIDTH/AXIL_DATA_WIDTH/8  native write data and byte enables
write_en_o  out  1  one-cycle native write strobe
addr_read_o  out  NATIVE_AW  native read word index
read_en_o  out  1  one-cycle native read strobe
data_i  in  AXIL_DATA_WIDTH  native read data, valid READ_LATENCY cycles after read_en_o

Behaviour:
- Reset (rst_i sampled high at posedge): all outputs 0, both FSMs idle. Any transaction in flight is dropped with no response. Native strobes are never asserted during reset.
- Address conversion: word index = addr >> log2(AXIL_DATA_WIDTH/8). Low offset bits are ignored (no misalignment error).
- Write FSM states: WR_IDLE (awready_o=wready_o=1), WR_WAIT_W (AW captured, wready_o=1 only), WR_WAIT_AW (W captured, awready_o=1 only), WR_EXEC, WR_RESP.
  - AW and W may handshake in the same cycle or in either order; each is captured on its own handshake.
  - Once both are captured: WR_EXEC for exactly one cycle. write_en_o=1 with registered addr/data/strb, but only if in range.
  - Then WR_RESP: bvalid_o=1, held with bresp stable until bready_i. Then WR_IDLE.
  - bresp = OKAY (2'b00), or SLVERR (2'b10) if out of range. Out-of-range writes never assert write_en_o.
  - Latency: AW and W in cycle 0 -> write_en_o in cycle 1 -> bvalid_o in cycle 2.
- Read FSM states: RD_IDLE (arready_o=1), RD_EXEC, RD_WAIT, RD_RESP.
  - On AR handshake: RD_EXEC. read_en_o=1 for one cycle, only if in range.
  - RD_WAIT counts READ_LATENCY cycles, then samples data_i into rdata_o.
  - RD_RESP: rvalid_o=1, rdata/rresp stable until rready_i. Then RD_IDLE.
  - Out of range: no read_en_o, rdata_o=0, rresp=SLVERR, same timing.
  - Latency with READ_LATENCY=1: AR in cycle 0, read_en_o in cycle 1, rvalid_o in cycle 3.
- Collision rule: if RD_EXEC would coincide with write_en_o=1, the read FSM stays in RD_EXEC one more cycle with read_en_o=0. read_en_o is issued the following cycle, so a read always observes a write issued in the same cycle.
- Only one outstanding transaction per channel; ready outputs stay low until the response completes.
- Back-to-back: a new AW/AR is accepted the cycle after the B/R handshake.

Optional Feature:
VGA_AXIL_WSTRB_EN.
- Defined: strb_o = captured wstrb_i.
  - wstrb_i = 0 is a legal no-op write: write_en_o stays low, bresp = OKAY.
- Undefined: wstrb_i is ignored and strb_o is tied to all ones. Every in-range write asserts write_en_o.

Test Plan:
Parameters for all scenarios: DATA_WIDTH=32, ADDR_WIDTH=16, NUM_WORDS=64, READ_LATENCY=2.
- Write 0x0000_00A5 to 0x0010 (AW and W same cycle), bready=1 -> write_en_o at cycle 1 with addr_write_o=4 and data_o=0xA5, bvalid at cycle 2, bresp=OKAY.
- W issued 3 cycles before AW, address 0x0020 -> awready_o held 1, wready_o 0 while waiting. Single write_en_o with addr_write_o=8; read of 0x0020 returns the written data with OKAY.
- Read 0x0100 (index 64) and write 0x0104 -> no native strobes; rresp=SLVERR with rdata_o=0; bresp=SLVERR.
- Simultaneous AR/AW/W to 0x0008, old value 0x11, new value 0x22 -> read_en_o delayed one cycle after write_en_o; rdata_o=0x22.
- rready held low for 5 cycles -> rvalid_o and rdata_o stable; arready_o stays 0 throughout.
- rst_i pulsed while in WR_RESP -> bvalid_o=0 the next cycle; no write_en_o; awready_o=wready_o=1 after reset deasserts.
